// File: rtl/regfile_pkg.sv
// Shared constants and FSM state encoding for the register-file writer.
package regfile_pkg;

    localparam int WIDTH  = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/reg_file_writer_if.sv
// Write/clear/observe bus of the register-file writer; the master drives requests, the slave answers.
interface reg_file_writer_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              clr_req;
    logic              busy;
    logic              clr_done;
    logic [ADDR_W-1:0] rd_addr;
    logic [WIDTH-1:0]  rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, clr_req, rd_addr,
        input  wr_ready, busy, clr_done, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, clr_req, rd_addr,
        output wr_ready, busy, clr_done, rd_data
    );

endinterface

// File: rtl/decoder_5to32.sv
// Enabled one-hot decoder: turns a register index into a per-register write enable.
module decoder_5to32 #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              en,
    input  logic [ADDR_W-1:0] addr,
    output logic [DEPTH-1:0]  onehot
);

    // NOTE: every signal assigned in always_comb gets a default first, otherwise a latch is inferred.
    always_comb begin
        onehot = '0;
        if (en) onehot[addr] = 1'b1;
    end

endmodule

// File: rtl/reg_file_writer.sv
// Register file with a valid/ready write port, a sequential clear engine and a combinational read port.
// Define REGFILE_ZERO_REG_EN to hard-wire register 0 to zero (writes to it are accepted and dropped).
module reg_file_writer #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
) (
    input logic               clk,
    input logic               rst,
    reg_file_writer_if.slave  bus
);

    import regfile_pkg::*;

    localparam int                DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_done_q, clr_done_d;
    logic              wr_ready_c, busy_c, clear_en;
    logic              wr_fire;
    logic [DEPTH-1:0]  wr_sel;
    logic [DEPTH-1:0]  wr_en;
    logic [WIDTH-1:0]  regs [DEPTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        wr_ready_c = 1'b0;
        busy_c     = 1'b0;
        clear_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                wr_ready_c = 1'b1;
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                busy_c   = 1'b1;
                clear_en = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
        end
    end

    assign wr_fire = bus.wr_valid && wr_ready_c;

    decoder_5to32 #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_decoder (
        .en     (wr_fire),
        .addr   (bus.wr_addr),
        .onehot (wr_sel)
    );

`ifdef REGFILE_ZERO_REG_EN
    assign wr_en = wr_sel & {{(DEPTH - 1){1'b1}}, 1'b0};
`else
    assign wr_en = wr_sel;
`endif

    // NOTE: the storage array is reset because a reset must leave every register reading zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (clear_en && (cnt_q == ADDR_W'(i))) regs[i] <= '0;
                else if (wr_en[i])                     regs[i] <= bus.wr_data;
            end
        end
    end

`ifdef REGFILE_ZERO_REG_EN
    assign bus.rd_data = (bus.rd_addr == '0) ? '0 : regs[bus.rd_addr];
`else
    assign bus.rd_data = regs[bus.rd_addr];
`endif

    assign bus.wr_ready = wr_ready_c;
    assign bus.busy     = busy_c;
    assign bus.clr_done = clr_done_q;

endmodule

// File: tb/tb_reg_file_writer.sv
// Self-checking bench for reg_file_writer: random writes and clear sequences against an array model.
module tb_reg_file_writer;

    import regfile_pkg::*;

    logic clk;
    logic rst;

    reg_file_writer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_file_writer #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [WIDTH-1:0] mdl [DEPTH];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [WIDTH-1:0] expect_rd(int a);
`ifdef REGFILE_ZERO_REG_EN
        if (a == 0) return '0;
`endif
        return mdl[a];
    endfunction

    function automatic void mdl_clear();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endfunction

    task automatic read_reg(input int a, output logic [WIDTH-1:0] d);
        bus.rd_addr = ADDR_W'(a);
        #1;
        d = bus.rd_data;
    endtask

    task automatic do_write(input int a, input logic [WIDTH-1:0] d);
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = ADDR_W'(a);
        bus.wr_data  = d;
        @(negedge clk);
        bus.wr_valid = 1'b0;
        mdl[a] = d;
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) do_write(i, $urandom);
    endtask

    task automatic test_reset();
        logic [WIDTH-1:0] got;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.clr_req  = 1'b0;
        bus.rd_addr  = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        mdl_clear();
        #2;
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy: got %b expected 0", bus.busy);
        end
        n_cmp++;
        if (bus.clr_done !== 1'b0) begin
            n_err++; $display("FAIL reset_clr_done: got %b expected 0", bus.clr_done);
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_reg(i, got);
            n_cmp++;
            if (got !== '0) begin
                n_err++; $display("FAIL reset_reg[%0d]: got %h expected 0", i, got);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (bus.wr_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_wr_ready: got %b expected 1", bus.wr_ready);
        end
    endtask

    task automatic test_single_write();
        logic [WIDTH-1:0] got;
        do_write(7, 32'hDEAD_BEEF);
        for (int i = 0; i < DEPTH; i++) begin
            read_reg(i, got);
            n_cmp++;
            if (got !== expect_rd(i)) begin
                n_err++; $display("FAIL single_write_reg[%0d]: got %h expected %h", i, got, expect_rd(i));
            end
        end
    endtask

    task automatic test_addr_boundaries();
        logic [WIDTH-1:0] got;
        logic [WIDTH-1:0] want0;
`ifdef REGFILE_ZERO_REG_EN
        want0 = '0;
`else
        want0 = 32'hCAFE_F00D;
`endif
        do_write(31, 32'h1234_5678);
        do_write(0, 32'hCAFE_F00D);
        read_reg(31, got);
        n_cmp++;
        if (got !== 32'h1234_5678) begin
            n_err++; $display("FAIL boundary_reg31: got %h expected 12345678", got);
        end
        read_reg(0, got);
        n_cmp++;
        if (got !== want0) begin
            n_err++; $display("FAIL boundary_reg0: got %h expected %h", got, want0);
        end
    endtask

    // Back-to-back random writes; also confirms the target shows its old value before the edge.
    task automatic test_back_to_back();
        logic [WIDTH-1:0] got;
        int pa = 0;
        logic [WIDTH-1:0] pd = '0;
        for (int k = 0; k < 64; k++) begin
            int a;
            logic [WIDTH-1:0] d;
            @(negedge clk);
            if (k > 0) begin
                mdl[pa] = pd;
                read_reg(pa, got);
                n_cmp++;
                if (got !== expect_rd(pa)) begin
                    n_err++; $display("FAIL b2b_after[%0d]: got %h expected %h", pa, got, expect_rd(pa));
                end
            end
            a = int'($urandom_range(DEPTH - 1, 0));
            d = $urandom;
            bus.wr_valid = 1'b1;
            bus.wr_addr  = ADDR_W'(a);
            bus.wr_data  = d;
            read_reg(a, got);
            n_cmp++;
            if (got !== expect_rd(a)) begin
                n_err++; $display("FAIL b2b_bypass[%0d]: got %h expected %h", a, got, expect_rd(a));
            end
            n_cmp++;
            if (bus.wr_ready !== 1'b1) begin
                n_err++; $display("FAIL b2b_wr_ready: got %b expected 1", bus.wr_ready);
            end
            pa = a;
            pd = d;
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        mdl[pa] = pd;
        for (int i = 0; i < DEPTH; i++) begin
            read_reg(i, got);
            n_cmp++;
            if (got !== expect_rd(i)) begin
                n_err++; $display("FAIL b2b_final[%0d]: got %h expected %h", i, got, expect_rd(i));
            end
        end
    endtask

    task automatic test_clear();
        logic [WIDTH-1:0] got;
        fill_random();
        @(negedge clk);
        bus.clr_req = 1'b1;
        #1;
        n_cmp++;
        if (bus.wr_ready !== 1'b1) begin
            n_err++; $display("FAIL clear_start_ready: got %b expected 1", bus.wr_ready);
        end
        @(negedge clk);
        for (int c = 0; c < DEPTH + 2; c++) begin
            if (c > 0) @(negedge clk);
            bus.clr_req = (c == 10);
            n_cmp++;
            if (bus.busy !== (c < DEPTH)) begin
                n_err++; $display("FAIL clear_busy c=%0d: got %b expected %b", c, bus.busy, (c < DEPTH));
            end
            n_cmp++;
            if (bus.wr_ready !== (c >= DEPTH)) begin
                n_err++; $display("FAIL clear_wr_ready c=%0d: got %b expected %b", c, bus.wr_ready, (c >= DEPTH));
            end
            n_cmp++;
            if (bus.clr_done !== (c == DEPTH)) begin
                n_err++; $display("FAIL clear_done c=%0d: got %b expected %b", c, bus.clr_done, (c == DEPTH));
            end
        end
        mdl_clear();
        for (int i = 0; i < DEPTH; i++) begin
            read_reg(i, got);
            n_cmp++;
            if (got !== '0) begin
                n_err++; $display("FAIL clear_reg[%0d]: got %h expected 0", i, got);
            end
        end
    endtask

    task automatic test_write_with_clear();
        logic [WIDTH-1:0] got;
        int done_at = -1;
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = ADDR_W'(3);
        bus.wr_data  = 32'h55;
        bus.clr_req  = 1'b1;
        #1;
        n_cmp++;
        if (bus.wr_ready !== 1'b1) begin
            n_err++; $display("FAIL wclr_ready: got %b expected 1", bus.wr_ready);
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.clr_req  = 1'b0;
        mdl[3] = 32'h55;
        read_reg(3, got);
        n_cmp++;
        if (got !== 32'h55) begin
            n_err++; $display("FAIL wclr_written: got %h expected 00000055", got);
        end
        for (int c = 0; c < DEPTH + 8; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.clr_done === 1'b1) begin
                done_at = c;
                break;
            end
        end
        n_cmp++;
        if (done_at != DEPTH) begin
            n_err++; $display("FAIL wclr_done_cycle: got %0d expected %0d", done_at, DEPTH);
        end
        mdl_clear();
        read_reg(3, got);
        n_cmp++;
        if (got !== '0) begin
            n_err++; $display("FAIL wclr_reg3: got %h expected 0", got);
        end
    endtask

    task automatic test_write_during_clear();
        logic [WIDTH-1:0] got;
        bit seen = 0;
        do_write(5, 32'h1234_0005);
        @(negedge clk);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req  = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = ADDR_W'(5);
        bus.wr_data  = 32'hAA;
        for (int c = 0; c < DEPTH + 8; c++) begin
            if (c > 0) @(negedge clk);
            if (bus.clr_done === 1'b1) begin
                seen = 1;
                break;
            end
            n_cmp++;
            if (bus.wr_ready !== 1'b0) begin
                n_err++; $display("FAIL wdc_ready_in_clear c=%0d: got %b expected 0", c, bus.wr_ready);
            end
        end
        n_cmp++;
        if (!seen) begin
            n_err++; $display("FAIL wdc_timeout: got no clr_done expected one within %0d cycles", DEPTH + 8);
        end
        mdl_clear();
        n_cmp++;
        if (bus.wr_ready !== 1'b1) begin
            n_err++; $display("FAIL wdc_ready_idle: got %b expected 1", bus.wr_ready);
        end
        read_reg(5, got);
        n_cmp++;
        if (got !== '0) begin
            n_err++; $display("FAIL wdc_reg5_at_done: got %h expected 0", got);
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        mdl[5] = 32'hAA;
        read_reg(5, got);
        n_cmp++;
        if (got !== 32'hAA) begin
            n_err++; $display("FAIL wdc_reg5_after: got %h expected 000000aa", got);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [WIDTH-1:0] got;
        fill_random();
        @(negedge clk);
        bus.clr_req = 1'b1;
        @(negedge clk);
        bus.clr_req = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        mdl_clear();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++; $display("FAIL rmc_busy: got %b expected 0", bus.busy);
        end
        for (int i = 0; i < DEPTH; i++) begin
            read_reg(i, got);
            n_cmp++;
            if (got !== '0) begin
                n_err++; $display("FAIL rmc_reg[%0d]: got %h expected 0", i, got);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < DEPTH + 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.clr_done !== 1'b0 || bus.busy !== 1'b0) begin
                n_err++; $display("FAIL rmc_after c=%0d: got done=%b busy=%b expected 0/0", c, bus.clr_done, bus.busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_addr_boundaries();
        test_back_to_back();
        test_clear();
        test_write_with_clear();
        test_write_during_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_file_writer.md
REG_FILE_WRITER -- requirements
Module: reg_file_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each register.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; DEPTH = 2**ADDR_W = 32 registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port wr_valid  input  1  write request.
REQ-006 SHALL have port wr_ready  output  1  write accepted this cycle when high with wr_valid.
REQ-007 SHALL have port wr_addr  input  ADDR_W  target register index.
REQ-008 SHALL have port wr_data  input  WIDTH  write data.
REQ-009 SHALL have port clr_req  input  1  request to zero all registers.
REQ-010 SHALL have port busy  output  1  clear sequence in progress.
REQ-011 SHALL have port clr_done  output  1  one-cycle pulse at clear completion.
REQ-012 SHALL have port rd_addr  input  ADDR_W  observation read index.
REQ-013 SHALL have port rd_data  output  WIDTH  contents of register rd_addr.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, CLEAR.
REQ-015 In IDLE, wr_ready SHALL be 1 and busy 0.
REQ-016 A write SHALL occur when wr_valid && wr_ready at a rising edge: reg[wr_addr] <= wr_data; all other registers unchanged.
REQ-017 Write target SHALL be selected via one-hot decode of wr_addr; exactly one register enabled per accepted write.
REQ-018 clr_req high in IDLE SHALL move FSM to CLEAR next cycle with clear counter cnt = 0.
REQ-019 Simultaneous accepted write and clr_req in IDLE: write SHALL complete that edge; clearing starts next cycle and overwrites it.
REQ-020 In CLEAR, each cycle SHALL set reg[cnt] <= 0 and increment cnt; wr_ready = 0, busy = 1.
REQ-021 When cnt == DEPTH-1 is cleared, FSM SHALL return to IDLE and clr_done SHALL be 1 for exactly the following cycle; full clear = DEPTH cycles.
REQ-022 clr_req and wr_valid SHALL be ignored during CLEAR; no write is queued.
REQ-023 rd_data SHALL be combinational reg[rd_addr]; no write-to-read bypass (new value visible the cycle after the write edge).

Reset
REQ-024 rst high SHALL immediately force all registers to 0, FSM to IDLE, cnt to 0, clr_done to 0, busy to 0; wr_ready = 1 once reset deasserts.
REQ-025 rst asserted mid-CLEAR SHALL abort the sequence; no clr_done pulse is produced.

Configuration
REQ-026 Macro REGFILE_ZERO_REG_EN defined: register 0 SHALL always read 0; writes to address 0 SHALL be accepted (handshake completes) but discarded.
REQ-027 Macro REGFILE_ZERO_REG_EN undefined: register 0 SHALL behave as an ordinary register.

Structure
REQ-028 Package regfile_pkg SHALL hold WIDTH, ADDR_W, DEPTH constants and the FSM state enum (IDLE, CLEAR).
REQ-029 Write-address decode SHALL be a sub-module decoder_5to32 (ADDR_W in, DEPTH one-hot out, enable input).

Verification
REQ-030 Reset, then write 0xDEADBEEF to addr 7 -> next cycle rd_addr=7 gives 0xDEADBEEF; all other addresses read 0.
REQ-031 Write 0x12345678 to addr 31, then 0xCAFEF00D to addr 0 -> addr 31 unchanged; addr 0 reads 0 with REGFILE_ZERO_REG_EN, 0xCAFEF00D without.
REQ-032 Fill all 32 registers, pulse clr_req -> busy=1 and wr_ready=0 for 32 cycles, clr_done pulses once, all registers read 0.
REQ-033 wr_valid with addr 3 data 0x55 same cycle as clr_req -> write accepted, reg 3 ends at 0 after clear.
REQ-034 wr_valid held during CLEAR with addr 5 data 0xAA -> no acceptance until IDLE; reg 5 is 0 at clr_done, 0xAA one cycle after the write is accepted in IDLE.
REQ-035 Assert rst at clear cycle 10 -> all registers 0, busy 0, no clr_done pulse.
